dwt_coeff_store: RTL and testbench

- Sits directly downstream of the Haar averaging/differencing stage and consumes its registered output beats.
- Each beat carries a packed {low, high} coefficient pair plus row/column and pixel pointers.
- Stores the low half into the low-band region and the high half into the high-band region of an internal frame buffer (deinterleaving the pass).
- After a full frame of pairs, streams the transformed frame out in raster order with a valid/ready handshake, feeding the next pass or the output DMA.

---
 rtl/dwt_coeff_store_if.sv | 31 +++
 rtl/dwt_coeff_store.sv | 169 ++++++++++++++++
 tb/tb_dwt_coeff_store.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dwt_coeff_store_if.sv
// Bundles the beat input bus and the raster output stream of dwt_coeff_store.
// The master side is the upstream Haar stage plus the downstream consumer.
// The slave side is the coefficient store itself.
interface dwt_coeff_store_if #(
   parameter int WIDTH = 256
) ();
   localparam int PW = $clog2(WIDTH);

   logic          i_pass;
   logic [15:0]   pixel_input;
   logic          i_valid;
   logic [PW-1:0] i_row_column_pointer;
   logic [PW-1:0] i_pixel_pointer;
   logic [7:0]    o_data;
   logic [PW-1:0] o_row;
   logic [PW-1:0] o_col;
   logic          o_valid;
   logic          i_ready;
   logic          o_frame_done;
   logic          o_overflow;

   modport master (
      output i_pass, pixel_input, i_valid, i_row_column_pointer, i_pixel_pointer, i_ready,
      input  o_data, o_row, o_col, o_valid, o_frame_done, o_overflow
   );

   modport slave (
      input  i_pass, pixel_input, i_valid, i_row_column_pointer, i_pixel_pointer, i_ready,
      output o_data, o_row, o_col, o_valid, o_frame_done, o_overflow
   );
endinterface

// File: rtl/dwt_coeff_store.sv
// Deinterleaving frame buffer behind the Haar stage. Each beat writes its low
// coefficient into bank L and its high coefficient into bank H. After a full
// frame of pairs the frame is streamed out in raster order.
//
// state | meaning
// FILL  | accept beats, write both banks, count beats up to HEIGHT*WIDTH/2
// DRAIN | raster read-out through a 2-stage pipeline; input beats are dropped
//
// Bank addressing, with H == W:
//   row pass:    addr = {row, col[PW-2:0]}, H bank when col[PW-1]
//   column pass: addr = {row[PW-2:0], col}, H bank when row[PW-1]
module dwt_coeff_store #(
   parameter int HEIGHT = 256,
   parameter int WIDTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   dwt_coeff_store_if.slave  bus
);
   localparam int PW    = $clog2(WIDTH);
   localparam int AW    = 2*PW - 1;
   localparam int NBEAT = HEIGHT*WIDTH/2;
   localparam int CW    = AW + 1;
   localparam logic [PW-1:0] LAST_ROW  = PW'(HEIGHT-1);
   localparam logic [PW-1:0] LAST_COL  = PW'(WIDTH-1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT-1);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pass_q, pass_d;

   logic [7:0]    bank_l [NBEAT];
   logic [7:0]    bank_h [NBEAT];

   logic          wr_en;
   logic          eff_pass;
   logic [AW-1:0] wr_addr;
   logic          unused_ptr_lsb;

   logic [PW-1:0] rd_row, rd_col;
   logic          rd_done;
   logic [AW-1:0] rd_addr;
   logic          rd_sel;
   logic          adv, issue, accept, last_accept;

   logic [7:0]    rd_l, rd_h;
   logic          s1_v, s1_sel;
   logic [PW-1:0] s1_row, s1_col;

   // The first beat of a frame decides the pass for its own write.
   assign eff_pass = (cnt_q == '0) ? bus.i_pass : pass_q;
   assign wr_en    = (state_q == FILL) && bus.i_valid;
   assign wr_addr  = eff_pass ? {bus.i_pixel_pointer[PW-1:1], bus.i_row_column_pointer}
                              : {bus.i_row_column_pointer, bus.i_pixel_pointer[PW-1:1]};
   assign unused_ptr_lsb = bus.i_pixel_pointer[0];

   assign rd_addr = pass_q ? {rd_row[PW-2:0], rd_col} : {rd_row, rd_col[PW-2:0]};
   assign rd_sel  = pass_q ? rd_row[PW-1] : rd_col[PW-1];

   // Pipeline moves only when the output register is empty or being taken.
   assign adv         = !bus.o_valid || bus.i_ready;
   assign issue       = (state_q == DRAIN) && !rd_done && adv;
   assign accept      = bus.o_valid && bus.i_ready;
   assign last_accept = accept && (bus.o_row == LAST_ROW) && (bus.o_col == LAST_COL);

   // State, beat counter and latched pass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state: count written beats in FILL, leave DRAIN on the last accept.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      case (state_q)
         FILL: begin
            if (bus.i_valid) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == '0) pass_d = bus.i_pass;
               if (cnt_q == LAST_BEAT) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_accept) begin
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Bank write port and registered read; contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank_l[wr_addr] <= bus.pixel_input[15:8];
         bank_h[wr_addr] <= bus.pixel_input[7:0];
      end
      if (issue) begin
         rd_l <= bank_l[rd_addr];
         rd_h <= bank_h[rd_addr];
      end
   end

   // Raster read pointer; parked at zero while filling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_row  <= '0;
         rd_col  <= '0;
         rd_done <= 1'b0;
      end else if (state_q == FILL) begin
         rd_row  <= '0;
         rd_col  <= '0;
         rd_done <= 1'b0;
      end else if (issue) begin
         if ((rd_row == LAST_ROW) && (rd_col == LAST_COL)) rd_done <= 1'b1;
         else {rd_row, rd_col} <= {rd_row, rd_col} + (2*PW)'(1);
      end
   end

   // Read stage tag and output register; both hold while the output is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v        <= 1'b0;
         s1_sel      <= 1'b0;
         s1_row      <= '0;
         s1_col      <= '0;
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
         bus.o_row   <= '0;
         bus.o_col   <= '0;
      end else if (adv) begin
         s1_v <= issue;
         if (issue) begin
            s1_sel <= rd_sel;
            s1_row <= rd_row;
            s1_col <= rd_col;
         end
         bus.o_valid <= s1_v;
         if (s1_v) begin
            bus.o_data <= s1_sel ? rd_h : rd_l;
            bus.o_row  <= s1_row;
            bus.o_col  <= s1_col;
         end
      end
   end

   // Frame-done pulse and sticky overflow for beats arriving during drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.o_frame_done <= 1'b0;
         bus.o_overflow   <= 1'b0;
      end else begin
         bus.o_frame_done <= last_accept;
         if ((state_q == DRAIN) && bus.i_valid) bus.o_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dwt_coeff_store.sv
// Directed bench for dwt_coeff_store: a 4x4 instance for the pass, stall,
// overflow and reset scenarios, and an 8x8 instance for back-to-back frames.
module tb_dwt_coeff_store;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dwt_coeff_store_if #(.WIDTH(4)) bus4 ();
   dwt_coeff_store_if #(.WIDTH(8)) bus8 ();

   dwt_coeff_store #(.HEIGHT(4), .WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   dwt_coeff_store #(.HEIGHT(8), .WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 4x4 raster model: mode 0 row pass, 1 column pass, 2 constant FF00 beats.
   function automatic logic [7:0] exp4(input int mode, input int r, input int c);
      case (mode)
         0:       return (c < 2) ? 8'(16 + 4*r + 2*c) : 8'(128 + 4*r + 2*(c-2));
         1:       return (r < 2) ? 8'(16 + 4*c + 2*r) : 8'(128 + 4*c + 2*(r-2));
         default: return (c < 2) ? 8'hFF : 8'h00;
      endcase
   endfunction

   // 8x8 raster model for row-pass frames; frame 1 is offset by 0x40.
   function automatic logic [7:0] exp8(input int f, input int r, input int c);
      int base;
      base = (f != 0) ? 64 : 0;
      return (c < 4) ? 8'(base + 4*r + c) : 8'(base + 128 + 4*r + (c-4));
   endfunction

   task automatic send4(input bit pass, input int mode);
      for (int rc = 0; rc < 4; rc++) begin
         for (int k = 0; k < 2; k++) begin
            bus4.i_valid              = 1'b1;
            bus4.i_pass               = (rc == 0 && k == 0) ? pass : 1'b0;
            bus4.i_row_column_pointer = 2'(rc);
            bus4.i_pixel_pointer      = 2'(2*k + (rc % 2));
            bus4.pixel_input          = (mode == 2) ? 16'hFF00
                                        : {8'(16 + 4*rc + 2*k), 8'(128 + 4*rc + 2*k)};
            tick();
         end
      end
      bus4.i_valid = 1'b0;
      bus4.i_pass  = 1'b0;
   endtask

   task automatic drain4(input int mode, input bit toggle, input int stop_after, input int exp_lat);
      int idx = 0;
      int cyc = 0;
      int first = -1;
      int last = 0;
      int fd = 0;
      bit rdy;
      while (idx < stop_after && cyc < 300) begin
         rdy = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         bus4.i_ready = rdy;
         if (bus4.o_frame_done) fd++;
         if (bus4.o_valid) begin
            if (first < 0) first = cyc;
            check_val("data4", 32'(bus4.o_data), 32'(exp4(mode, idx / 4, idx % 4)));
            check_val("pos4", 32'({bus4.o_row, bus4.o_col}), 32'(idx));
            if (rdy) begin
               last = cyc;
               idx++;
            end
         end
         tick();
         cyc++;
      end
      bus4.i_ready = 1'b1;
      check_val("count4", 32'(idx), 32'(stop_after));
      if (exp_lat >= 0) check_val("latency4", 32'(first), 32'(exp_lat));
      if (!toggle && stop_after == 16) check_val("no_bubble4", 32'(last - first), 32'd15);
      if (stop_after == 16) begin
         check_val("fd_early4", 32'(fd), 32'd0);
         check_val("fd_pulse4", 32'(bus4.o_frame_done), 32'd1);
         tick();
         check_val("fd_end4", 32'(bus4.o_frame_done), 32'd0);
         check_val("idle4", 32'(bus4.o_valid), 32'd0);
      end
   endtask

   task automatic check_reset4();
      check_val("rst_valid", 32'(bus4.o_valid), 32'd0);
      check_val("rst_data", 32'(bus4.o_data), 32'd0);
      check_val("rst_row", 32'(bus4.o_row), 32'd0);
      check_val("rst_col", 32'(bus4.o_col), 32'd0);
      check_val("rst_fd", 32'(bus4.o_frame_done), 32'd0);
      check_val("rst_ovf", 32'(bus4.o_overflow), 32'd0);
   endtask

   initial begin
      int idx;
      int cyc;
      int first;

      bus4.i_valid = 1'b0; bus4.i_pass = 1'b0; bus4.pixel_input = '0;
      bus4.i_row_column_pointer = '0; bus4.i_pixel_pointer = '0; bus4.i_ready = 1'b0;
      bus8.i_valid = 1'b0; bus8.i_pass = 1'b0; bus8.pixel_input = '0;
      bus8.i_row_column_pointer = '0; bus8.i_pixel_pointer = '0; bus8.i_ready = 1'b0;

      #12;
      check_reset4();
      rst = 1'b1;
      tick();

      // row pass
      send4(1'b0, 0);
      drain4(0, 1'b0, 16, 2);
      check_val("ovf_clean", 32'(bus4.o_overflow), 32'd0);

      // column pass, pass bit only present on the first beat
      send4(1'b1, 1);
      drain4(1, 1'b0, 16, 2);

      // backpressure with ready pattern 1,0,0,1
      send4(1'b0, 0);
      drain4(0, 1'b1, 16, 2);

      // overflow: ninth beat one cycle into drain
      send4(1'b0, 0);
      bus4.i_valid = 1'b1;
      bus4.i_row_column_pointer = '0;
      bus4.i_pixel_pointer = '0;
      bus4.pixel_input = 16'hEEEE;
      tick();
      bus4.i_valid = 1'b0;
      check_val("ovf_set", 32'(bus4.o_overflow), 32'd1);
      drain4(0, 1'b0, 16, 1);
      check_val("ovf_sticky", 32'(bus4.o_overflow), 32'd1);

      // reset mid-drain after five outputs
      send4(1'b0, 0);
      drain4(0, 1'b0, 5, 2);
      #2;
      rst = 1'b0;
      #1;
      check_reset4();
      #3;
      rst = 1'b1;
      tick();
      send4(1'b0, 2);
      drain4(2, 1'b0, 16, 2);

      // 8x8 back-to-back frames
      for (int rc = 0; rc < 8; rc++) begin
         for (int k = 0; k < 4; k++) begin
            bus8.i_valid = 1'b1;
            bus8.i_row_column_pointer = 3'(rc);
            bus8.i_pixel_pointer = 3'(2*k);
            bus8.pixel_input = {8'(4*rc + k), 8'(128 + 4*rc + k)};
            tick();
         end
      end
      bus8.i_valid = 1'b0;
      bus8.i_ready = 1'b1;
      idx = 0;
      cyc = 0;
      while (!bus8.o_frame_done && cyc < 300) begin
         if (bus8.o_valid) begin
            check_val("data8_f0", 32'(bus8.o_data), 32'(exp8(0, idx / 8, idx % 8)));
            idx++;
         end
         tick();
         cyc++;
      end
      check_val("count8_f0", 32'(idx), 32'd64);
      check_val("fd8_f0", 32'(bus8.o_frame_done), 32'd1);
      // frame 2 starts in the same cycle as the frame-done pulse
      for (int rc = 0; rc < 8; rc++) begin
         for (int k = 0; k < 4; k++) begin
            bus8.i_valid = 1'b1;
            bus8.i_row_column_pointer = 3'(rc);
            bus8.i_pixel_pointer = 3'(2*k);
            bus8.pixel_input = {8'(64 + 4*rc + k), 8'(192 + 4*rc + k)};
            tick();
         end
      end
      bus8.i_valid = 1'b0;
      idx = 0;
      cyc = 0;
      first = -1;
      while (idx < 64 && cyc < 300) begin
         if (bus8.o_valid) begin
            if (first < 0) first = cyc;
            check_val("data8_f1", 32'(bus8.o_data), 32'(exp8(1, idx / 8, idx % 8)));
            check_val("pos8_f1", 32'({bus8.o_row, bus8.o_col}), 32'(idx));
            idx++;
         end
         tick();
         cyc++;
      end
      check_val("count8_f1", 32'(idx), 32'd64);
      check_val("latency8_f1", 32'(first), 32'd2);
      check_val("fd8_f1", 32'(bus8.o_frame_done), 32'd1);
      check_val("ovf8", 32'(bus8.o_overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
